gpio_seg_regs: RTL and testbench

- Memory-mapped GPIO register block that sits directly upstream of the eight-digit seven-segment display driver.
- Holds the 32-bit display value on seg_num, drives the board LEDs, and exposes debounced switches.
- Captures button press events as sticky, write-1-to-clear bits.
- Slave on the core's simple single-beat peripheral bus.

---
 rtl/gpio_pkg.sv | 19 +
 rtl/gpio_debounce.sv | 52 +++++
 rtl/gpio_seg_regs.sv | 136 +++++++++++++
 tb/tb_gpio_seg_regs.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared constants and helpers for the GPIO / seven-segment register block.
package gpio_pkg;

   localparam logic [3:0] GPIO_OFF_SEG = 4'h0;
   localparam logic [3:0] GPIO_OFF_LED = 4'h4;
   localparam logic [3:0] GPIO_OFF_SW  = 4'h8;
   localparam logic [3:0] GPIO_OFF_BTN = 4'hC;

   localparam int BTN_IE_LSB = 16;

   function automatic logic [31:0] strb_mask(input logic [3:0] strb);
      logic [31:0] m;
      m = '0;
      for (int b = 0; b < 4; b++)
         if (strb[b]) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Per-bit two-flop synchronizer and hold-time debouncer.
module gpio_debounce #(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = 20000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_raw,
   output logic [WIDTH-1:0] o_stable,
   output logic [WIDTH-1:0] o_rise
);

   localparam int CW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_s2;
   logic [WIDTH-1:0] r_stable;
   logic [WIDTH-1:0] r_rise;
   logic [CW-1:0]    r_cnt [WIDTH];

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_s1     <= '0;
         r_s2     <= '0;
         r_stable <= '0;
         r_rise   <= '0;
         for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      end else begin
         r_s1   <= i_raw;
         r_s2   <= r_s1;
         r_rise <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            // any cycle back at the stable level restarts the hold time
            if (r_s2[i] == r_stable[i]) begin
               r_cnt[i] <= '0;
            end else if (r_cnt[i] == CMAX) begin
               r_cnt[i]    <= '0;
               r_stable[i] <= r_s2[i];
               r_rise[i]   <= r_s2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign o_stable = r_stable;
   assign o_rise   = r_rise;

endmodule

// File: rtl/gpio_seg_regs.sv
// Memory-mapped GPIO block: segment value, LEDs, debounced switches,
// sticky button events with interrupt enable.
module gpio_seg_regs
   import gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int NUM_SW          = 16,
   parameter int NUM_BTN         = 5,
   parameter int NUM_LED         = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               req,
   input  logic               we,
   input  logic [3:0]         addr,
   input  logic [31:0]        wdata,
   input  logic [3:0]         wstrb,
   output logic [31:0]        rdata,
   output logic               ack,
   input  logic [NUM_SW-1:0]  sw_in,
   input  logic [NUM_BTN-1:0] btn_in,
   output logic [31:0]        seg_num,
   output logic [NUM_LED-1:0] led,
   output logic               irq
);

   logic [31:0]        r_seg;
   logic [NUM_LED-1:0] r_led;
   logic [NUM_BTN-1:0] r_evt;
   logic [NUM_BTN-1:0] r_ie;
   logic [31:0]        r_rdata;
   logic               r_ack;
   logic               r_irq;

   logic [NUM_SW-1:0]  w_sw_stable;
   logic [NUM_SW-1:0]  w_sw_rise;
   logic [NUM_BTN-1:0] w_btn_stable;
   logic [NUM_BTN-1:0] w_btn_rise;

   logic               w_acc;
   logic               w_wr;
   logic [31:0]        w_mask;
   logic [31:0]        w_wbits;
   logic [31:0]        w_ie_mask;
   logic [31:0]        w_ie_bits;
   logic [NUM_BTN-1:0] w_clr;
   logic               w_sel_seg;
   logic               w_sel_led;
   logic               w_sel_sw;
   logic               w_sel_btn;
   logic [31:0]        w_rd;
   logic               w_unused;

   gpio_debounce #(
      .WIDTH           (NUM_SW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_sw_db (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (sw_in),
      .o_stable (w_sw_stable),
      .o_rise   (w_sw_rise)
   );

   gpio_debounce #(
      .WIDTH           (NUM_BTN),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_btn_db (
      .clk      (clk),
      .rst      (rst),
      .i_raw    (btn_in),
      .o_stable (w_btn_stable),
      .o_rise   (w_btn_rise)
   );

   // an ack cycle never accepts, so back-to-back requests alternate
   assign w_acc   = req & ~r_ack;
   assign w_wr    = w_acc & we;
   assign w_mask  = strb_mask(wstrb);
   assign w_wbits = wdata & w_mask;

   assign w_sel_seg = (addr[3:2] == GPIO_OFF_SEG[3:2]);
   assign w_sel_led = (addr[3:2] == GPIO_OFF_LED[3:2]);
   assign w_sel_sw  = (addr[3:2] == GPIO_OFF_SW[3:2]);
   assign w_sel_btn = (addr[3:2] == GPIO_OFF_BTN[3:2]);

   assign w_ie_mask = w_mask >> BTN_IE_LSB;
   assign w_ie_bits = w_wbits >> BTN_IE_LSB;
   assign w_clr     = (w_wr && w_sel_btn) ? w_wbits[NUM_BTN-1:0] : '0;

   always_comb begin
      w_rd = '0;
      unique case (1'b1)
         w_sel_seg: w_rd = r_seg;
         w_sel_led: w_rd = 32'(r_led);
         w_sel_sw:  w_rd = 32'(w_sw_stable);
         w_sel_btn: w_rd = 32'(r_evt) | (32'(r_ie) << BTN_IE_LSB);
         default:   w_rd = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_seg   <= '0;
         r_led   <= '0;
         r_evt   <= '0;
         r_ie    <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_irq   <= 1'b0;
      end else begin
         r_ack   <= w_acc;
         r_rdata <= (w_acc && !we) ? w_rd : '0;
         r_irq   <= |(r_evt & r_ie);
         // a rise in the same cycle as its clear leaves the bit set
         r_evt   <= (r_evt & ~w_clr) | w_btn_rise;
         if (w_wr && w_sel_seg)
            r_seg <= (r_seg & ~w_mask) | w_wbits;
         if (w_wr && w_sel_led)
            r_led <= (r_led & ~w_mask[NUM_LED-1:0])
                   | w_wbits[NUM_LED-1:0];
         if (w_wr && w_sel_btn)
            r_ie <= (r_ie & ~w_ie_mask[NUM_BTN-1:0])
                  | w_ie_bits[NUM_BTN-1:0];
      end
   end

   assign w_unused = ^{addr[1:0], w_btn_stable, w_sw_rise};

   assign rdata   = r_rdata;
   assign ack     = r_ack;
   assign seg_num = r_seg;
   assign led     = r_led;
   assign irq     = r_irq;

endmodule

// File: tb/tb_gpio_seg_regs.sv
// Directed and randomized checks of gpio_seg_regs against a register model.
module tb_gpio_seg_regs;

   localparam int NSW  = 16;
   localparam int NBTN = 5;
   localparam int NLED = 16;
   localparam int DB   = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            req = 1'b0;
   logic            we = 1'b0;
   logic [3:0]      addr = '0;
   logic [31:0]     wdata = '0;
   logic [3:0]      wstrb = '0;
   logic [NSW-1:0]  sw_in = '0;
   logic [NBTN-1:0] btn_in = '0;
   wire  [31:0]     rdata;
   wire             ack;
   wire  [31:0]     seg_num;
   wire  [NLED-1:0] led;
   wire             irq;

   int checks = 0;
   int failures = 0;

   logic [31:0]     m_seg = '0;
   logic [NLED-1:0] m_led = '0;
   logic [NBTN-1:0] m_ie = '0;
   logic [NBTN-1:0] m_evt = '0;
   logic [NSW-1:0]  m_sw = '0;

   gpio_seg_regs #(
      .DEBOUNCE_CYCLES (DB),
      .NUM_SW          (NSW),
      .NUM_BTN         (NBTN),
      .NUM_LED         (NLED)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .we      (we),
      .addr    (addr),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .rdata   (rdata),
      .ack     (ack),
      .sw_in   (sw_in),
      .btn_in  (btn_in),
      .seg_num (seg_num),
      .led     (led),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // returns in the ack cycle, #1 after the edge that raised ack
   task automatic bus(input logic w, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output int lat);
      req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
      lat = 0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         if (ack) begin
            lat = i;
            break;
         end
      end
      rd = rdata;
      req = 1'b0; we = 1'b0;
      if (lat == 0) check("ack_timeout", 32'd0, 32'd1);
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [3:0] a);
      case (a[3:2])
         2'd0:    return m_seg;
         2'd1:    return {16'h0, m_led};
         2'd2:    return {16'h0, m_sw};
         default: return ({27'h0, m_ie} << 16) | {27'h0, m_evt};
      endcase
   endfunction

   task automatic model_wr(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      logic [31:0] t;
      case (a[3:2])
         2'd0: m_seg = merge(m_seg, d, s);
         2'd1: begin
            t = merge({16'h0, m_led}, d, s);
            m_led = t[15:0];
         end
         2'd2: ;
         default: begin
            t = merge(32'h0, d, s);
            m_evt = m_evt & ~t[4:0];
            t = merge({11'h0, m_ie, 16'h0}, d, s);
            m_ie = t[20:16];
         end
      endcase
   endtask

   initial begin
      logic [31:0] rd;
      int lat;
      logic [3:0] ra;
      logic [31:0] rdd;
      logic [3:0] rs;

      rst = 1'b0;
      step(2);
      check("rst_seg", seg_num, 32'h0);
      check("rst_led", {16'h0, led}, 32'h0);
      check("rst_ack", {31'h0, ack}, 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_irq", {31'h0, irq}, 32'h0);
      rst = 1'b1;
      step(1);

      bus(1'b1, 4'h0, 32'h12345678, 4'hF, rd, lat);
      check("t1_ack_lat", lat, 32'd1);
      check("t1_seg_in_ack", seg_num, 32'h12345678);
      step(1);
      check("t1_ack_pulse", {31'h0, ack}, 32'h0);
      check("t1_rdata_idle", rdata, 32'h0);
      bus(1'b0, 4'h0, 32'h0, 4'h0, rd, lat);
      check("t1_read_seg", rd, 32'h12345678);

      bus(1'b1, 4'h0, 32'hAABBCCDD, 4'b0101, rd, lat);
      check("t2_seg_strb", seg_num, 32'h12BB56DD);
      bus(1'b1, 4'h4, 32'hFFFFFFFF, 4'hF, rd, lat);
      check("t2_led_out", {16'h0, led}, 32'h0000FFFF);
      bus(1'b0, 4'h4, 32'h0, 4'h0, rd, lat);
      check("t2_read_led", rd, 32'h0000FFFF);
      m_seg = 32'h12BB56DD;
      m_led = 16'hFFFF;

      sw_in[3] = 1'b1;
      step(3);
      sw_in[3] = 1'b0;
      step(10);
      bus(1'b0, 4'h8, 32'h0, 4'h0, rd, lat);
      check("t3_glitch", rd, 32'h0);
      sw_in[3] = 1'b1;
      step(5);
      bus(1'b0, 4'h8, 32'h0, 4'h0, rd, lat);
      check("t3_before_latency", rd, 32'h0);
      bus(1'b0, 4'h8, 32'h0, 4'h0, rd, lat);
      check("t3_after_latency", rd, 32'h8);
      sw_in[3] = 1'b0;
      step(10);
      sw_in[3] = 1'b1;
      step(6);
      bus(1'b0, 4'h8, 32'h0, 4'h0, rd, lat);
      check("t3_at_latency", rd, 32'h8);
      m_sw = 16'h0008;

      bus(1'b1, 4'hC, 32'h00040000, 4'b0100, rd, lat);
      btn_in[2] = 1'b1;
      step(7);
      check("t4_irq_pre", {31'h0, irq}, 32'h0);
      step(1);
      check("t4_irq_rise", {31'h0, irq}, 32'h1);
      step(2);
      btn_in[2] = 1'b0;
      step(10);
      bus(1'b0, 4'hC, 32'h0, 4'h0, rd, lat);
      check("t4_evt_sticky", rd, 32'h00040004);
      bus(1'b1, 4'hC, 32'h00000004, 4'b0001, rd, lat);
      check("t4_irq_hold", {31'h0, irq}, 32'h1);
      step(1);
      check("t4_irq_fall", {31'h0, irq}, 32'h0);
      bus(1'b0, 4'hC, 32'h0, 4'h0, rd, lat);
      check("t4_evt_cleared", rd, 32'h00040000);

      btn_in[0] = 1'b1;
      step(10);
      btn_in[0] = 1'b0;
      step(10);
      bus(1'b0, 4'hC, 32'h0, 4'h0, rd, lat);
      check("t5_first_press", rd, 32'h00040001);
      btn_in[0] = 1'b1;
      step(6);
      bus(1'b1, 4'hC, 32'h00000001, 4'b0001, rd, lat);
      step(4);
      btn_in[0] = 1'b0;
      step(10);
      bus(1'b0, 4'hC, 32'h0, 4'h0, rd, lat);
      check("t5_set_wins", rd, 32'h00040001);
      bus(1'b1, 4'hC, 32'h00000001, 4'b0001, rd, lat);
      bus(1'b0, 4'hC, 32'h0, 4'h0, rd, lat);
      check("t5_cleared", rd, 32'h00040000);
      m_ie = 5'h04;
      m_evt = '0;

      for (int it = 0; it < 60; it++) begin
         if (it % 10 == 0) begin
            sw_in = NSW'($urandom);
            step(DB + 4);
            m_sw = sw_in;
         end
         ra = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) begin
            rdd = $urandom;
            rs = 4'($urandom);
            bus(1'b1, ra, rdd, rs, rd, lat);
            model_wr(ra, rdd, rs);
            check("rnd_seg", seg_num, m_seg);
            check("rnd_led", {16'h0, led}, {16'h0, m_led});
         end else begin
            bus(1'b0, ra, 32'h0, 4'h0, rd, lat);
            check("rnd_read", rd, model_rd(ra));
         end
      end
      step(2);
      check("rnd_irq", {31'h0, irq}, 32'h0);

      req = 1'b1; we = 1'b1; addr = 4'h0;
      wdata = 32'hCAFEF00D; wstrb = 4'hF;
      rst = 1'b0;
      step(1);
      req = 1'b0; we = 1'b0;
      check("t6a_no_ack", {31'h0, ack}, 32'h0);
      check("t6a_seg", seg_num, 32'h0);
      rst = 1'b1;
      step(1);
      check("t6a_still_no_ack", {31'h0, ack}, 32'h0);

      req = 1'b1; we = 1'b1; addr = 4'h0;
      wdata = 32'h5A5A1234; wstrb = 4'hF;
      step(1);
      rst = 1'b0;
      req = 1'b0; we = 1'b0;
      step(1);
      check("t6b_ack_dropped", {31'h0, ack}, 32'h0);
      check("t6b_seg", seg_num, 32'h0);
      rst = 1'b1;
      req = 1'b1; we = 1'b0; addr = 4'h0;
      for (int k = 0; k < 4; k++) begin
         check("t6_ack_pattern", {31'h0, ack}, k % 2);
         step(1);
      end
      req = 1'b0;
      step(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
